// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
//
// Scan controller for a 4x4 matrix push-button keypad. Drives one column low
// at a time, synchronises the raw active-low rows, debounces both press and
// release, and reports one key code per validated press.
//
// Optional feature macro: KEYPAD_REPEAT_EN
//   When defined, a held key re-pulses key_valid after REPEAT_DLY cycles and
//   then every REPEAT_RATE cycles until it is released. When undefined, each
//   press yields exactly one pulse and no repeat logic is built.
//
// Parameters:
//   SCAN_DIV      clk cycles each column is driven before rows are sampled (>=3)
//   DEBOUNCE_CNT  consecutive stable samples needed for press and release (>=1)
//   REPEAT_DLY    cycles from the press pulse to the first repeat (>=2)
//   REPEAT_RATE   cycles between later repeats (>=2)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   scan_en    1 = scan; 0 = idle in SCAN with all columns released
//   row[3:0]   raw keypad rows, active low, asynchronous to clk
//   col[3:0]   registered one-hot active-low column strobe
//   key_valid  single-cycle pulse, key_code holds a new debounced press
//   key_code   col_idx*4 + row_idx of the last validated press
//   key_held   high from the press pulse until release debounce completes
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 16,
    parameter int unsigned DEBOUNCE_CNT = 1000,
    parameter int unsigned REPEAT_DLY   = 50000,
    parameter int unsigned REPEAT_RATE  = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_en,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks (no hardware).
    // -------------------------------------------------------------------------
    generate
        if (SCAN_DIV < 3) begin : g_bad_scan_div
            $error("keypad_scan_ctrl: SCAN_DIV must be at least 3");
        end
        if (DEBOUNCE_CNT < 1) begin : g_bad_debounce
            $error("keypad_scan_ctrl: DEBOUNCE_CNT must be at least 1");
        end
        if ((REPEAT_DLY < 2) || (REPEAT_RATE < 2)) begin : g_bad_repeat
            $error("keypad_scan_ctrl: REPEAT_DLY and REPEAT_RATE must be at least 2");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Widths and constants
    // -------------------------------------------------------------------------
    localparam int unsigned DWW = $clog2(SCAN_DIV);
    localparam int unsigned DBW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

    localparam logic [DWW-1:0] DWELL_LAST = DWW'(SCAN_DIV - 1);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CNT - 1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        col_drive = ~(4'b0001 << idx);
    endfunction

    // Exactly one row pulled low: inverted value is a non-zero power of two.
    function automatic logic single_low(input logic [3:0] r);
        logic [3:0] low;
        low        = ~r;
        single_low = (low != 4'b0000) && ((low & (low - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] r);
        row_index = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!r[i]) begin
                row_index = i[1:0];
            end
        end
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [3:0]     row_m;
    logic [3:0]     row_s;
    logic [1:0]     state;
    logic [DWW-1:0] dwell;
    logic [DBW-1:0] db_cnt;
    logic [1:0]     col_idx;
    logic [3:0]     cap_row;

    logic [1:0]     state_n;
    logic [DWW-1:0] dwell_n;
    logic [DBW-1:0] db_cnt_n;
    logic [1:0]     col_idx_n;
    logic [3:0]     cap_row_n;
    logic [3:0]     col_n;
    logic           key_valid_n;
    logic [3:0]     key_code_n;
    logic           key_held_n;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned RPW     = $clog2(REP_MAX);
    localparam logic [RPW-1:0] REP_FIRST_LAST = RPW'(REPEAT_DLY - 1);
    localparam logic [RPW-1:0] REP_NEXT_LAST  = RPW'(REPEAT_RATE - 1);

    logic [RPW-1:0] rep_cnt;
    logic           rep_first;
    logic [RPW-1:0] rep_cnt_n;
    logic           rep_first_n;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_n     = state;
        dwell_n     = dwell;
        db_cnt_n    = db_cnt;
        col_idx_n   = col_idx;
        cap_row_n   = cap_row;
        col_n       = col;
        key_valid_n = 1'b0;
        key_code_n  = key_code;
        key_held_n  = key_held;
`ifdef KEYPAD_REPEAT_EN
        // Repeat timing only runs while in PRESSED; anywhere else it rests.
        rep_cnt_n   = '0;
        rep_first_n = 1'b1;
`endif

        case (state)
            ST_SCAN: begin
                if (!scan_en) begin
                    // Idle: release every column but remember which one was
                    // active so scanning resumes there with a full dwell.
                    dwell_n = '0;
                    col_n   = 4'b1111;
                end else if (dwell == DWELL_LAST) begin
                    dwell_n = '0;
                    if (single_low(row_s)) begin
                        cap_row_n = row_s;
                        db_cnt_n  = '0;
                        col_n     = col_drive(col_idx);
                        state_n   = ST_DEBOUNCE;
                    end else begin
                        // Nothing pressed, or a ghost/multi-key pattern.
                        col_idx_n = col_idx + 2'd1;
                        col_n     = col_drive(col_idx + 2'd1);
                    end
                end else begin
                    dwell_n = dwell + DWW'(1);
                    col_n   = col_drive(col_idx);
                end
            end

            ST_DEBOUNCE: begin
                if (row_s == cap_row) begin
                    if (db_cnt == DB_LAST) begin
                        db_cnt_n    = '0;
                        key_valid_n = 1'b1;
                        key_held_n  = 1'b1;
                        key_code_n  = {col_idx, row_index(cap_row)};
                        state_n     = ST_PRESSED;
                    end else begin
                        db_cnt_n = db_cnt + DBW'(1);
                    end
                end else begin
                    // Bounce: abandon this column without reporting anything.
                    db_cnt_n  = '0;
                    dwell_n   = '0;
                    col_idx_n = col_idx + 2'd1;
                    col_n     = col_drive(col_idx + 2'd1);
                    state_n   = ST_SCAN;
                end
            end

            ST_PRESSED: begin
                if (row_s == 4'b1111) begin
                    db_cnt_n = '0;
                    state_n  = ST_RELEASE;
                end
`ifdef KEYPAD_REPEAT_EN
                else begin
                    rep_first_n = rep_first;
                    if (rep_cnt == (rep_first ? REP_FIRST_LAST : REP_NEXT_LAST)) begin
                        key_valid_n = 1'b1;
                        rep_cnt_n   = '0;
                        rep_first_n = 1'b0;
                    end else begin
                        rep_cnt_n = rep_cnt + RPW'(1);
                    end
                end
`endif
            end

            ST_RELEASE: begin
                if (row_s == 4'b1111) begin
                    if (db_cnt == DB_LAST) begin
                        db_cnt_n   = '0;
                        dwell_n    = '0;
                        key_held_n = 1'b0;
                        col_idx_n  = col_idx + 2'd1;
                        col_n      = col_drive(col_idx + 2'd1);
                        state_n    = ST_SCAN;
                    end else begin
                        db_cnt_n = db_cnt + DBW'(1);
                    end
                end else begin
                    db_cnt_n = '0;
                end
            end

            default: begin
                state_n = ST_SCAN;
                dwell_n = '0;
                col_n   = col_drive(col_idx);
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_m     <= 4'b1111;
            row_s     <= 4'b1111;
            state     <= ST_SCAN;
            dwell     <= '0;
            db_cnt    <= '0;
            col_idx   <= 2'd0;
            cap_row   <= 4'b1111;
            col       <= 4'b1110;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            key_held  <= 1'b0;
        end else begin
            row_m     <= row;
            row_s     <= row_m;
            state     <= state_n;
            dwell     <= dwell_n;
            db_cnt    <= db_cnt_n;
            col_idx   <= col_idx_n;
            cap_row   <= cap_row_n;
            col       <= col_n;
            key_valid <= key_valid_n;
            key_code  <= key_code_n;
            key_held  <= key_held_n;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else begin
            rep_cnt   <= rep_cnt_n;
            rep_first <= rep_first_n;
        end
    end
`endif

endmodule
